// File: rtl/ram_cmd_initiator.sv
// Host request -> serial RAM command sequencer (address/data opcode pairs, read timeout).
// Optional RAM_CMD_ADDR_CACHE_EN: skip the address command when it repeats the last one issued.
module ram_cmd_initiator #(
    parameter int RD_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [9:0] din,
    output logic       rx_valid,
    input  logic [7:0] dout,
    input  logic       tx_valid
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ADDR = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] RD_ADDR = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] RD_WAIT = 3'd5;
    localparam logic [2:0] RSP     = 3'd6;

    localparam int            CW       = $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic          wr_q, wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_hit, rd_hit;

`ifdef RAM_CMD_ADDR_CACHE_EN
    logic [7:0] wc_addr_q, rc_addr_q;
    logic       wc_vld_q, rc_vld_q;

    assign wr_hit = wc_vld_q && (wc_addr_q == req_addr);
    assign rd_hit = rc_vld_q && (rc_addr_q == req_addr);

    // The cached address is what the RAM currently holds for that direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_addr_q <= 8'h00;
            wc_vld_q  <= 1'b0;
            rc_addr_q <= 8'h00;
            rc_vld_q  <= 1'b0;
        end else begin
            if (state_q == WR_ADDR) begin
                wc_addr_q <= addr_q;
                wc_vld_q  <= 1'b1;
            end
            if (state_q == RD_ADDR) begin
                rc_addr_q <= addr_q;
                rc_vld_q  <= 1'b1;
            end
        end
    end
`else
    assign wr_hit = 1'b0;
    assign rd_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 8'h00;
                    err_d   = 1'b0;
                    if (req_wr) state_d = wr_hit ? WR_DATA : WR_ADDR;
                    else        state_d = rd_hit ? RD_DATA : RD_ADDR;
                end
            end
            WR_ADDR: state_d = WR_DATA;
            WR_DATA: state_d = RSP;
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
            end
            RD_WAIT: begin
                if (tx_valid) begin
                    rdata_d = dout;
                    err_d   = 1'b0;
                    state_d = RSP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 8'h00;
                    err_d   = 1'b1;
                    state_d = RSP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        rx_valid = 1'b1;
        case (state_q)
            WR_ADDR: din = {2'b00, addr_q};
            WR_DATA: din = {2'b01, wdata_q};
            RD_ADDR: din = {2'b10, addr_q};
            RD_DATA: din = {2'b11, 8'h00};
            default: begin
                din      = 10'h000;
                rx_valid = 1'b0;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_rdata = wr_q ? 8'h00 : rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_ram_cmd_initiator.sv
// Directed bench for ram_cmd_initiator with a behavioural RAM answering one cycle after RD_DATA.
module tb_ram_cmd_initiator;

    localparam bit CACHE =
`ifdef RAM_CMD_ADDR_CACHE_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [7:0] rsp_rdata;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout = 8'h00;
    logic       tx_valid = 1'b0;

    ram_cmd_initiator #(.RD_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .din(din), .rx_valid(rx_valid), .dout(dout), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // RAM model: sees commands mid-cycle, answers reads during the following cycle.
    logic [7:0] mem [256];
    logic [7:0] m_waddr = 8'h00, m_raddr = 8'h00;
    logic       pend = 1'b0;
    logic       ram_en = 1'b1;
    int         cmd_cnt = 0;
    logic [9:0] last_cmd = 10'h000;

    always @(negedge clk) begin
        if (!rst_n) begin
            tx_valid = 1'b0;
            pend     = 1'b0;
        end else begin
            tx_valid = pend && ram_en;
            dout     = pend ? mem[m_raddr] : 8'h00;
            pend     = 1'b0;
            if (rx_valid) begin
                cmd_cnt++;
                last_cmd = din;
                case (din[9:8])
                    2'b00: m_waddr = din[7:0];
                    2'b01: mem[m_waddr] = din[7:0];
                    2'b10: m_raddr = din[7:0];
                    default: pend = 1'b1;
                endcase
            end
        end
    end

    // Expected latency; tracks last-issued addresses so the cached build is also predicted.
    logic       c_wv = 1'b0, c_rv = 1'b0;
    logic [7:0] c_wa = 8'h00, c_ra = 8'h00;

    function automatic int lat_exp(input logic wr, input logic [7:0] a, input int base);
        int r;
        r = base;
        if (wr) begin
            if (CACHE && c_wv && c_wa == a) r = r - 1;
            c_wv = 1'b1; c_wa = a;
        end else begin
            if (CACHE && c_rv && c_ra == a) r = r - 1;
            c_rv = 1'b1; c_ra = a;
        end
        return r;
    endfunction

    task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd, output logic er);
        int guard;
        lat = -1; rd = 8'h00; er = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid = 1'b0; req_wr = ~wr; req_addr = 8'hEE; req_wdata = 8'hEE;
        for (int k = 1; k < 60; k++) begin
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int         lat, el, c0;
        logic [7:0] rd;
        logic       er;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        vecs[0]  = '{1'b1, 8'h80, 8'h11, 8'h00};
        vecs[1]  = '{1'b1, 8'h81, 8'h22, 8'h00};
        vecs[2]  = '{1'b0, 8'h80, 8'h00, 8'h11};
        vecs[3]  = '{1'b0, 8'h81, 8'h00, 8'h22};
        vecs[4]  = '{1'b0, 8'h05, 8'h00, 8'h5F};
        vecs[5]  = '{1'b1, 8'hFF, 8'h00, 8'h00};
        vecs[6]  = '{1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 8'h00, 8'hFF, 8'h00};
        vecs[8]  = '{1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[9]  = '{1'b1, 8'h80, 8'h33, 8'h00};
        vecs[10] = '{1'b0, 8'h80, 8'h00, 8'h33};
        vecs[11] = '{1'b0, 8'h80, 8'h00, 8'h33};

        // Reset values
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err",   rsp_err,   0);
        check("rst_rx_valid",  rx_valid,  0);
        check("rst_din",       din,       0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write 0x3C <- 0xA5, cycle by cycle
        el = lat_exp(1'b1, 8'h3C, 3);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h3C; req_wdata = 8'hA5;
        check("w1_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("w1_k1_rx", rx_valid, 1);
        check("w1_k1_din", din, 10'h03C);
        @(negedge clk);
        check("w1_k2_rx", rx_valid, 1);
        check("w1_k2_din", din, 10'h1A5);
        @(negedge clk);
        check("w1_k3_rsp_valid", rsp_valid, (el == 3) ? 1 : 0);
        check("w1_k3_err", rsp_err, 0);
        check("w1_k3_rx", rx_valid, 0);
        check("w1_k3_din", din, 0);

        // Read 0x3C, RAM answering
        el = lat_exp(1'b0, 8'h3C, 4);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h3C;
        @(negedge clk);
        req_valid = 1'b0;
        check("r1_k1_din", din, 10'h23C);
        @(negedge clk);
        check("r1_k2_din", din, 10'h300);
        @(negedge clk);
        check("r1_k3_rx", rx_valid, 0);
        check("r1_k3_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("r1_k4_rsp_valid", rsp_valid, (el == 4) ? 1 : 0);
        check("r1_rdata", rsp_rdata, 8'hA5);
        check("r1_err", rsp_err, 0);

        // Table of transactions
        foreach (vecs[i]) begin
            el = lat_exp(vecs[i].wr, vecs[i].addr, vecs[i].wr ? 3 : 4);
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rd, er);
            check($sformatf("vec%0d_lat", i), lat, el);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), er, 0);
        end

        // Read timeout: 15 RD_WAIT cycles then error response
        ram_en = 1'b0;
        el = lat_exp(1'b0, 8'h3C, 18);
        run_txn(1'b0, 8'h3C, 8'h00, lat, rd, er);
        check("to_lat", lat, el);
        check("to_rdata", rd, 0);
        check("to_err", er, 1);
        ram_en = 1'b1;

        // Backpressure: response held while rsp_ready=0
        el = lat_exp(1'b0, 8'h3C, 4);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h3C; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k < 40; k++) begin
            if (rsp_valid) begin lat = k; break; end
            @(negedge clk);
        end
        check("bp_lat", lat, el);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rdata", rsp_rdata, 8'hA5);
            check("bp_err", rsp_err, 0);
            check("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", rsp_valid, 0);
        check("bp_release_ready", req_ready, 1);

        // Reset during RD_WAIT
        ram_en = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h44;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rx", rx_valid, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_din", din, 0);
        c_wv = 1'b0; c_rv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ram_en = 1'b1;
        el = lat_exp(1'b1, 8'h44, 3);
        run_txn(1'b1, 8'h44, 8'h77, lat, rd, er);
        check("post_rst_w_lat", lat, el);
        check("post_rst_w_err", er, 0);
        el = lat_exp(1'b0, 8'h44, 4);
        run_txn(1'b0, 8'h44, 8'h00, lat, rd, er);
        check("post_rst_r_lat", lat, el);
        check("post_rst_r_rdata", rd, 8'h77);

`ifdef RAM_CMD_ADDR_CACHE_EN
        // Repeated write address skips the address command
        run_txn(1'b1, 8'h10, 8'h01, lat, rd, er);
        check("cache_w1_lat", lat, 3);
        c0 = cmd_cnt;
        run_txn(1'b1, 8'h10, 8'h55, lat, rd, er);
        check("cache_w2_lat", lat, 2);
        check("cache_w2_cmds", cmd_cnt - c0, 1);
        check("cache_w2_cmd", last_cmd, 10'h155);
`else
        c0 = cmd_cnt;
        run_txn(1'b1, 8'h10, 8'h55, lat, rd, er);
        check("nocache_w_cmds", cmd_cnt - c0, 2);
        check("nocache_w_cmd", last_cmd, 10'h155);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_cmd_initiator.md
RAM_CMD_INITIATOR -- requirements
Module: ram_cmd_initiator

Interface
REQ-001 The block SHALL have parameter RD_TIMEOUT, default 15, meaning the number of RD_WAIT cycles before a read is declared failed.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid  input  1  host request present.
REQ-005 The block SHALL have port req_ready  output  1  block can accept a request.
REQ-006 The block SHALL have port req_wr  input  1  1 = write, 0 = read.
REQ-007 The block SHALL have port req_addr  input  8  memory address.
REQ-008 The block SHALL have port req_wdata  input  8  write data, ignored on reads.
REQ-009 The block SHALL have port rsp_valid  output  1  response present.
REQ-010 The block SHALL have port rsp_ready  input  1  host accepts the response.
REQ-011 The block SHALL have port rsp_rdata  output  8  read data; 0 for writes and for errors.
REQ-012 The block SHALL have port rsp_err  output  1  read timed out.
REQ-013 The block SHALL have port din  output  10  RAM command, {opcode[1:0], payload[7:0]}.
REQ-014 The block SHALL have port rx_valid  output  1  din qualifier to the RAM.
REQ-015 The block SHALL have port dout  input  8  RAM read data.
REQ-016 The block SHALL have port tx_valid  input  1  RAM read data valid.

Function
REQ-017 The block SHALL use the RAM opcodes 00 = write address, 01 = write data, 10 = read address, 11 = read data.
REQ-018 The block SHALL implement the FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, RD_WAIT and RSP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid and req_ready both 1.
REQ-020 On acceptance the block SHALL register req_wr, req_addr and req_wdata, then go to WR_ADDR if req_wr=1 or to RD_ADDR otherwise.
REQ-021 In each of WR_ADDR, WR_DATA, RD_ADDR and RD_DATA the block SHALL assert rx_valid for exactly one cycle with the matching opcode and registered payload.
REQ-022 State order SHALL be WR_ADDR -> WR_DATA -> RSP for writes, and RD_ADDR -> RD_DATA -> RD_WAIT for reads.
REQ-023 rx_valid SHALL be 0 in IDLE, RD_WAIT and RSP; din SHALL be 0 whenever rx_valid is 0.
REQ-024 In RD_WAIT the block SHALL sample tx_valid starting the cycle after RD_DATA. Stale tx_valid from an earlier read cannot be mistaken because RD_DATA's own command is what the RAM answers.
REQ-025 In RD_WAIT, tx_valid=1 SHALL capture dout into rsp_rdata with rsp_err=0 and go to RSP.
REQ-026 In RD_WAIT, if tx_valid stays 0 for RD_TIMEOUT cycles, the block SHALL set rsp_rdata=0 and rsp_err=1 and go to RSP.
REQ-027 In RSP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1; the block then returns to IDLE.
REQ-028 Minimum latency from acceptance to rsp_valid SHALL be 3 cycles for a write and 4 cycles for a read.
REQ-029 Host inputs SHALL be ignored outside IDLE; req_valid asserted during a transaction stays pending until req_ready returns.
REQ-030 Only one transaction SHALL be outstanding at any time.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE and set req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rx_valid=0, din=0, clearing all registered request fields and the timeout counter.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no response.
REQ-033 After rst_n deasserts, the first accepted request SHALL start cleanly from IDLE.

Configuration
REQ-034 With macro RAM_CMD_ADDR_CACHE_EN defined, the block SHALL track the last write and read addresses issued, each with its own valid bit cleared by reset.
REQ-035 With RAM_CMD_ADDR_CACHE_EN defined, a request whose address matches the valid cached address of its direction SHALL skip WR_ADDR or RD_ADDR, reducing write latency to 2 and read latency to 3.
REQ-036 Without RAM_CMD_ADDR_CACHE_EN defined, every transaction SHALL issue its address command.

Verification
REQ-037 Reset, then write addr 0x3C data 0xA5 -> din 0x03C then 0x1A5 on consecutive cycles; rsp_valid 3 cycles after acceptance with rsp_err=0.
REQ-038 Then read addr 0x3C with the RAM model answering -> din 0x23C then 0x300; rsp_rdata=0xA5, rsp_err=0.
REQ-039 Read with tx_valid held at 0 and RD_TIMEOUT=15 -> rsp_valid after 15 RD_WAIT cycles with rsp_err=1 and rsp_rdata=0x00.
REQ-040 Hold rsp_ready=0 for 5 cycles in RSP -> rsp_valid and data held stable and req_ready=0 throughout; return to IDLE the cycle after rsp_ready=1.
REQ-041 Assert rst_n=0 during RD_WAIT -> rx_valid=0 and rsp_valid=0 immediately; the next write completes normally.
REQ-042 With RAM_CMD_ADDR_CACHE_EN defined, two writes to 0x10 -> the second issues only 0x1xx (write data) and responds 2 cycles after acceptance.
